aux_req_arbiter: RTL and testbench

Parametrised N-requester AUX transaction arbiter with retry and failure reporting, sitting between the AUX requesters (SPM, LPM, CR FSM, EQ FSM, and any future masters) and the AUX control path. It grants one requester at a time using fixed or round-robin priority, and latches that requester's command. It then issues the command downstream and retries on DEFER or timeout up to a limit. Completion and failure are reported back only to the owning requester.

---
 rtl/aux_arb_pkg.sv | 16 +
 rtl/aux_rr_pick.sv | 34 +++
 rtl/aux_req_arbiter.sv | 169 ++++++++++++++++
 tb/tb_aux_req_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aux_arb_pkg.sv
// Shared definitions for the AUX request arbiter: reply codes and FSM states.
package aux_arb_pkg;

    localparam logic [1:0] ACK_C   = 2'b00;
    localparam logic [1:0] NACK_C  = 2'b01;
    localparam logic [1:0] DEFER_C = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        FAIL  = 3'd4
    } arb_state_e;

endpackage

// File: rtl/aux_rr_pick.sv
// Combinational requester picker: lowest index in fixed mode, or the first
// requester at/after rr_ptr (wrapping) in round-robin mode.
module aux_rr_pick #(
    parameter int N_REQ   = 4,
    parameter int IDX_W   = 2,
    parameter bit RR_MODE = 1'b1
) (
    input  logic [N_REQ-1:0] req_vld,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_any
);

    always_comb begin
        int cand;
        win_oh  = '0;
        win_idx = '0;
        win_any = 1'b0;
        cand    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = RR_MODE ? (int'(rr_ptr) + k) : k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!win_any && req_vld[cand]) begin
                win_any      = 1'b1;
                win_oh[cand] = 1'b1;
                win_idx      = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/aux_req_arbiter.sv
// N-requester AUX transaction arbiter: grants one requester, latches its
// command, issues it downstream and retries on DEFER/timeout up to a limit.
module aux_req_arbiter
    import aux_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 20,
    parameter int LEN_W     = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_RETRY = 3,
    parameter bit RR_MODE   = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_vld,
    input  logic [N_REQ-1:0]           req_i2c_native,
    input  logic [N_REQ*2-1:0]         req_cmd,
    input  logic [N_REQ*ADDR_W-1:0]    req_address,
    input  logic [N_REQ*LEN_W-1:0]     req_len,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    input  logic [1:0]                 reply_ack,
    input  logic                       reply_ack_vld,
    input  logic                       timer_timeout,
    output logic [N_REQ-1:0]           req_grant,
    output logic [N_REQ-1:0]           req_done,
    output logic [N_REQ-1:0]           req_failed,
    output logic                       ctrl_tr_vld,
    output logic [1:0]                 ctrl_msg_cmd,
    output logic [ADDR_W-1:0]          ctrl_msg_address,
    output logic [LEN_W-1:0]           ctrl_msg_len,
    output logic [DATA_W-1:0]          ctrl_msg_data,
    output logic                       ctrl_i2c_native,
    output logic                       arb_busy,
    output logic [$clog2(N_REQ)-1:0]   arb_owner
);

    localparam int IDX_W   = $clog2(N_REQ);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    arb_state_e           state_reg;
    logic [IDX_W-1:0]     rr_ptr_reg;
    logic [IDX_W-1:0]     owner_reg;
    logic [RETRY_W-1:0]   retry_cnt_reg;
    logic [N_REQ-1:0]     done_reg;
    logic [N_REQ-1:0]     failed_reg;
    logic                 tr_vld_reg;
    logic [1:0]           cmd_reg;
    logic [ADDR_W-1:0]    addr_reg;
    logic [LEN_W-1:0]     len_reg;
    logic [DATA_W-1:0]    data_reg;
    logic                 i2c_reg;

    logic [N_REQ-1:0]     pick_oh;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic [N_REQ-1:0]     owner_oh;

    logic [1:0]           cmd_arr  [N_REQ];
    logic [ADDR_W-1:0]    addr_arr [N_REQ];
    logic [LEN_W-1:0]     len_arr  [N_REQ];
    logic [DATA_W-1:0]    data_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_fields
            assign cmd_arr[gi]  = req_cmd[2*gi +: 2];
            assign addr_arr[gi] = req_address[ADDR_W*gi +: ADDR_W];
            assign len_arr[gi]  = req_len[LEN_W*gi +: LEN_W];
            assign data_arr[gi] = req_data[DATA_W*gi +: DATA_W];
            assign owner_oh[gi] = (owner_reg == IDX_W'(gi));
        end
    endgenerate

    aux_rr_pick #(
        .N_REQ   (N_REQ),
        .IDX_W   (IDX_W),
        .RR_MODE (RR_MODE)
    ) u_pick (
        .req_vld (req_vld),
        .rr_ptr  (rr_ptr_reg),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .win_any (pick_any)
    );

    // Grant is presented in the same IDLE cycle the request is seen, so the
    // requester can drop req_vld while the latched copy takes over.
    assign req_grant = (state_reg == IDLE && rst_n) ? pick_oh : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            owner_reg     <= '0;
            retry_cnt_reg <= '0;
            done_reg      <= '0;
            failed_reg    <= '0;
            tr_vld_reg    <= 1'b0;
            cmd_reg       <= '0;
            addr_reg      <= '0;
            len_reg       <= '0;
            data_reg      <= '0;
            i2c_reg       <= 1'b0;
        end else begin
            done_reg   <= '0;
            failed_reg <= '0;
            tr_vld_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pick_any) begin
                        cmd_reg       <= cmd_arr[pick_idx];
                        addr_reg      <= addr_arr[pick_idx];
                        len_reg       <= len_arr[pick_idx];
                        data_reg      <= data_arr[pick_idx];
                        i2c_reg       <= req_i2c_native[pick_idx];
                        owner_reg     <= pick_idx;
                        retry_cnt_reg <= '0;
                        tr_vld_reg    <= 1'b1;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    // A reply in the same cycle as a timeout takes precedence.
                    if (reply_ack_vld && reply_ack == ACK_C) begin
                        done_reg  <= owner_oh;
                        state_reg <= DONE;
                    end else if ((reply_ack_vld && reply_ack == DEFER_C) ||
                                 (!reply_ack_vld && timer_timeout)) begin
                        if (int'(retry_cnt_reg) < MAX_RETRY) begin
                            retry_cnt_reg <= retry_cnt_reg + RETRY_W'(1);
                            tr_vld_reg    <= 1'b1;
                            state_reg     <= ISSUE;
                        end else begin
                            failed_reg <= owner_oh;
                            state_reg  <= FAIL;
                        end
                    end else if (reply_ack_vld) begin
                        // NACK_C and the reserved code both end the transaction.
                        failed_reg <= owner_oh;
                        state_reg  <= FAIL;
                    end
                end
                DONE, FAIL: begin
                    rr_ptr_reg <= (owner_reg == IDX_W'(N_REQ - 1)) ? '0
                                                                  : owner_reg + IDX_W'(1);
                    state_reg  <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_done         = done_reg;
    assign req_failed       = failed_reg;
    assign ctrl_tr_vld      = tr_vld_reg;
    assign ctrl_msg_cmd     = cmd_reg;
    assign ctrl_msg_address = addr_reg;
    assign ctrl_msg_len     = len_reg;
    assign ctrl_msg_data    = data_reg;
    assign ctrl_i2c_native  = i2c_reg;
    assign arb_busy         = (state_reg != IDLE);
    assign arb_owner        = owner_reg;

endmodule

// File: tb/tb_aux_req_arbiter.sv
// Directed bench for aux_req_arbiter: a round-robin and a fixed-priority
// instance share all inputs; each scenario task checks its own expectations.
module tb_aux_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 20;
    localparam int LW = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [N-1:0]    req_vld;
    logic [N-1:0]    req_i2c_native;
    logic [2*N-1:0]  req_cmd;
    logic [N*AW-1:0] req_address;
    logic [N*LW-1:0] req_len;
    logic [N*DW-1:0] req_data;
    logic [1:0]      reply_ack;
    logic            reply_ack_vld;
    logic            timer_timeout;

    logic [N-1:0]  rr_grant, rr_done, rr_failed;
    logic          rr_tr_vld, rr_i2c, rr_busy;
    logic [1:0]    rr_cmd;
    logic [AW-1:0] rr_addr;
    logic [LW-1:0] rr_len;
    logic [DW-1:0] rr_data;
    logic [1:0]    rr_owner;

    logic [N-1:0]  fx_grant, fx_done, fx_failed;
    logic          fx_tr_vld, fx_i2c, fx_busy;
    logic [1:0]    fx_cmd;
    logic [AW-1:0] fx_addr;
    logic [LW-1:0] fx_len;
    logic [DW-1:0] fx_data;
    logic [1:0]    fx_owner;

    int errors = 0;
    int checks = 0;

    aux_req_arbiter #(.N_REQ(N), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW),
                      .MAX_RETRY(3), .RR_MODE(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_i2c_native(req_i2c_native),
        .req_cmd(req_cmd), .req_address(req_address), .req_len(req_len), .req_data(req_data),
        .reply_ack(reply_ack), .reply_ack_vld(reply_ack_vld), .timer_timeout(timer_timeout),
        .req_grant(rr_grant), .req_done(rr_done), .req_failed(rr_failed),
        .ctrl_tr_vld(rr_tr_vld), .ctrl_msg_cmd(rr_cmd), .ctrl_msg_address(rr_addr),
        .ctrl_msg_len(rr_len), .ctrl_msg_data(rr_data), .ctrl_i2c_native(rr_i2c),
        .arb_busy(rr_busy), .arb_owner(rr_owner)
    );

    aux_req_arbiter #(.N_REQ(N), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW),
                      .MAX_RETRY(3), .RR_MODE(1'b0)) u_fx (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_i2c_native(req_i2c_native),
        .req_cmd(req_cmd), .req_address(req_address), .req_len(req_len), .req_data(req_data),
        .reply_ack(reply_ack), .reply_ack_vld(reply_ack_vld), .timer_timeout(timer_timeout),
        .req_grant(fx_grant), .req_done(fx_done), .req_failed(fx_failed),
        .ctrl_tr_vld(fx_tr_vld), .ctrl_msg_cmd(fx_cmd), .ctrl_msg_address(fx_addr),
        .ctrl_msg_len(fx_len), .ctrl_msg_data(fx_data), .ctrl_i2c_native(fx_i2c),
        .arb_busy(fx_busy), .arb_owner(fx_owner)
    );

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0; req_vld = '0; reply_ack_vld = 1'b0; timer_timeout = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One ACKed transaction: IDLE, ISSUE, WAIT (ACK), DONE. Returns observed grants/dones.
    task automatic run_ack(input logic [N-1:0] vld, output logic [N-1:0] g_rr,
                           output logic [N-1:0] g_fx, output logic [N-1:0] d_rr,
                           output logic [N-1:0] d_fx);
        @(negedge clk); req_vld = vld; #1;
        g_rr = rr_grant; g_fx = fx_grant;
        @(negedge clk); #1;
        @(negedge clk); reply_ack = 2'b00; reply_ack_vld = 1'b1; #1;
        @(negedge clk); reply_ack_vld = 1'b0; #1;
        d_rr = rr_done; d_fx = fx_done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_vld = '0; reply_ack = 2'b00; reply_ack_vld = 1'b0; timer_timeout = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({rr_grant, rr_done, rr_failed} !== 12'h000) begin
            errors++; $display("FAIL reset_pulses: got %h want 000", {rr_grant, rr_done, rr_failed}); end
        checks++; if ({rr_tr_vld, rr_busy, rr_owner} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b want 0000", {rr_tr_vld, rr_busy, rr_owner}); end
        checks++; if ({rr_cmd, rr_addr, rr_len, rr_data, rr_i2c} !== '0) begin
            errors++; $display("FAIL reset_msg: got addr %h cmd %b want 0", rr_addr, rr_cmd); end
        $display("reset: grant=%b busy=%b owner=%0d", rr_grant, rr_busy, rr_owner);
        rst_n = 1'b1;
    endtask

    task automatic test_single_ack();
        @(negedge clk); req_vld = 4'b0100; #1;
        checks++; if (rr_grant !== 4'b0100) begin
            errors++; $display("FAIL single_grant: got %b want 0100", rr_grant); end
        @(negedge clk); req_vld = '0; #1;
        checks++; if (rr_tr_vld !== 1'b1) begin
            errors++; $display("FAIL single_tr_vld: got %b want 1", rr_tr_vld); end
        checks++; if (rr_addr !== 20'h00202 || rr_cmd !== 2'b01) begin
            errors++; $display("FAIL single_msg: got addr %h cmd %b want 00202 01", rr_addr, rr_cmd); end
        checks++; if (rr_owner !== 2'd2 || rr_busy !== 1'b1) begin
            errors++; $display("FAIL single_owner: got owner %0d busy %b want 2 1", rr_owner, rr_busy); end
        @(negedge clk); reply_ack = 2'b00; reply_ack_vld = 1'b1; #1;
        @(negedge clk); reply_ack_vld = 1'b0; #1;
        checks++; if (rr_done !== 4'b0100 || rr_failed !== 4'b0000) begin
            errors++; $display("FAIL single_done: got done %b failed %b want 0100 0000", rr_done, rr_failed); end
        @(negedge clk); #1;
        checks++; if (rr_busy !== 1'b0) begin
            errors++; $display("FAIL single_idle: got busy %b want 0", rr_busy); end
        $display("single_ack: addr=%h done seen, busy=%b", rr_addr, rr_busy);
    endtask

    task automatic test_rr_fairness();
        logic [N-1:0] exp_g [5];
        logic [N-1:0] g_rr, g_fx, d_rr, d_fx;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            run_ack(4'b1111, g_rr, g_fx, d_rr, d_fx);
            checks++; if (g_rr !== exp_g[i]) begin
                errors++; $display("FAIL rr_grant[%0d]: got %b want %b", i, g_rr, exp_g[i]); end
            checks++; if (d_rr !== exp_g[i]) begin
                errors++; $display("FAIL rr_done[%0d]: got %b want %b", i, d_rr, exp_g[i]); end
            $display("rr txn %0d: grant=%b done=%b", i, g_rr, d_rr);
        end
    endtask

    task automatic test_fixed_priority();
        logic [N-1:0] exp_g [5];
        logic [N-1:0] g_rr, g_fx, d_rr, d_fx;
        exp_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        for (int i = 0; i < 5; i++) begin
            run_ack(4'b1111, g_rr, g_fx, d_rr, d_fx);
            checks++; if (g_fx !== 4'b0001 || d_fx !== 4'b0001) begin
                errors++; $display("FAIL fixed_grant[%0d]: got grant %b done %b want 0001 0001", i, g_fx, d_fx); end
            checks++; if (g_rr !== exp_g[i]) begin
                errors++; $display("FAIL rr_continue[%0d]: got %b want %b", i, g_rr, exp_g[i]); end
            $display("fixed txn %0d: fx_grant=%b rr_grant=%b", i, g_fx, g_rr);
        end
        req_vld = '0;
        @(negedge clk);
    endtask

    task automatic test_frozen_fields();
        @(negedge clk); req_vld = 4'b1000; #1;
        @(negedge clk); req_vld = '0; req_address[3*AW +: AW] = 20'hFFFFF;
        reply_ack = 2'b00; reply_ack_vld = 1'b1; #1;
        @(negedge clk); reply_ack_vld = 1'b0; #1;
        checks++; if (rr_addr !== 20'h00203 || rr_len !== 8'h13 || rr_data !== 8'hA3) begin
            errors++; $display("FAIL frozen_msg: got %h %h %h want 00203 13 a3", rr_addr, rr_len, rr_data); end
        checks++; if (rr_cmd !== 2'b00 || rr_i2c !== 1'b1 || rr_owner !== 2'd3) begin
            errors++; $display("FAIL frozen_ctl: got cmd %b i2c %b owner %0d want 00 1 3", rr_cmd, rr_i2c, rr_owner); end
        @(negedge clk); #1;
        checks++; if (rr_busy !== 1'b1 || rr_done !== 4'b0000 || rr_tr_vld !== 1'b0) begin
            errors++; $display("FAIL issue_reply_ignored: got busy %b done %b tr %b want 1 0000 0", rr_busy, rr_done, rr_tr_vld); end
        reply_ack_vld = 1'b1;
        @(negedge clk); reply_ack_vld = 1'b0; #1;
        checks++; if (rr_done !== 4'b1000) begin
            errors++; $display("FAIL frozen_done: got %b want 1000", rr_done); end
        req_address[3*AW +: AW] = 20'h00203;
        @(negedge clk);
        $display("frozen: addr held at %h, done=1000", rr_addr);
    endtask

    task automatic retry_run(input logic [N-1:0] vld, input bit alternate, input string tag);
        int pulses, fail_cyc;
        logic [N-1:0] fail_val;
        logic done_seen;
        pulses = 0; fail_cyc = -1; fail_val = '0; done_seen = 1'b0;
        @(negedge clk); req_vld = vld; #1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            req_vld = '0;
            if (!alternate) begin
                reply_ack = 2'b10; reply_ack_vld = 1'b1; timer_timeout = 1'b0;
            end else begin
                reply_ack = 2'b10;
                reply_ack_vld = (k == 4 || k == 8);
                timer_timeout = (k == 2 || k == 6);
            end
            #1;
            if (rr_tr_vld === 1'b1) pulses++;
            if (rr_failed !== '0 && fail_cyc < 0) begin fail_cyc = k; fail_val = rr_failed; end
            if (rr_done !== '0) done_seen = 1'b1;
        end
        reply_ack_vld = 1'b0; timer_timeout = 1'b0;
        checks++; if (pulses !== 4) begin
            errors++; $display("FAIL %s_issues: got %0d want 4", tag, pulses); end
        checks++; if (fail_cyc !== 9 || fail_val !== vld) begin
            errors++; $display("FAIL %s_failed: got %b at %0d want %b at 9", tag, fail_val, fail_cyc, vld); end
        checks++; if (done_seen !== 1'b0 || rr_busy !== 1'b0) begin
            errors++; $display("FAIL %s_end: got done_seen %b busy %b want 0 0", tag, done_seen, rr_busy); end
        $display("%s: issues=%0d failed=%b at cycle %0d", tag, pulses, fail_val, fail_cyc);
    endtask

    task automatic test_retry_fail();
        retry_run(4'b0010, 1'b0, "retry_defer");
        retry_run(4'b1000, 1'b1, "retry_mixed");
    endtask

    task automatic test_reply_priority();
        logic [1:0] codes [3];
        logic [N-1:0] exp_d, exp_f;
        int pulses;
        codes = '{2'b00, 2'b01, 2'b11};
        for (int c = 0; c < 3; c++) begin
            exp_d = (c == 0) ? 4'b0001 : 4'b0000;
            exp_f = (c == 0) ? 4'b0000 : 4'b0001;
            pulses = 0;
            @(negedge clk); req_vld = 4'b0001; #1;
            @(negedge clk); req_vld = '0; #1;
            if (rr_tr_vld === 1'b1) pulses++;
            @(negedge clk); reply_ack = codes[c]; reply_ack_vld = 1'b1; timer_timeout = 1'b1; #1;
            @(negedge clk); reply_ack_vld = 1'b0; timer_timeout = 1'b0; #1;
            if (rr_tr_vld === 1'b1) pulses++;
            checks++; if (rr_done !== exp_d || rr_failed !== exp_f) begin
                errors++; $display("FAIL reply_result[%0d]: got done %b failed %b want %b %b", c, rr_done, rr_failed, exp_d, exp_f); end
            @(negedge clk); #1;
            if (rr_tr_vld === 1'b1) pulses++;
            checks++; if (pulses !== 1 || rr_busy !== 1'b0) begin
                errors++; $display("FAIL reply_noretry[%0d]: got issues %0d busy %b want 1 0", c, pulses, rr_busy); end
            $display("reply code %b + timeout: done=%b failed=%b issues=%0d", codes[c], exp_d, exp_f, pulses);
        end
    endtask

    task automatic test_reset_wait();
        logic seen;
        seen = 1'b0;
        @(negedge clk); req_vld = 4'b0101; #1;
        checks++; if (rr_grant !== 4'b0100) begin
            errors++; $display("FAIL rstw_pre_grant: got %b want 0100", rr_grant); end
        @(negedge clk); #1;
        @(negedge clk); rst_n = 1'b0; #1;
        @(negedge clk); rst_n = 1'b1; #1;
        if (rr_done !== '0 || rr_failed !== '0) seen = 1'b1;
        checks++; if ({rr_tr_vld, rr_busy, rr_owner, rr_addr} !== '0) begin
            errors++; $display("FAIL rstw_outputs: got tr %b busy %b owner %0d addr %h want 0", rr_tr_vld, rr_busy, rr_owner, rr_addr); end
        checks++; if (rr_grant !== 4'b0001) begin
            errors++; $display("FAIL rstw_regrant: got %b want 0001", rr_grant); end
        @(negedge clk); req_vld = '0; #1;
        if (rr_done !== '0 || rr_failed !== '0) seen = 1'b1;
        checks++; if (rr_tr_vld !== 1'b1 || rr_addr !== 20'h00200) begin
            errors++; $display("FAIL rstw_issue: got tr %b addr %h want 1 00200", rr_tr_vld, rr_addr); end
        @(negedge clk); reply_ack = 2'b00; reply_ack_vld = 1'b1; #1;
        if (rr_done !== '0 || rr_failed !== '0) seen = 1'b1;
        @(negedge clk); reply_ack_vld = 1'b0; #1;
        checks++; if (seen !== 1'b0 || rr_done !== 4'b0001) begin
            errors++; $display("FAIL rstw_done: got stray %b done %b want 0 0001", seen, rr_done); end
        $display("reset_wait: regrant=0001 done=%b", rr_done);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            req_cmd[2*i +: 2]         = 2'(i) ^ 2'b11;
            req_address[AW*i +: AW]   = 20'h00200 + AW'(i);
            req_len[LW*i +: LW]       = 8'h10 + LW'(i);
            req_data[DW*i +: DW]      = 8'hA0 + DW'(i);
            req_i2c_native[i]         = 1'(i);
        end
        test_reset();
        test_single_ack();
        test_rr_fairness();
        test_fixed_priority();
        test_frozen_fields();
        test_retry_fail();
        test_reply_priority();
        test_reset_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
